instruction_fetch: RTL and testbench

Fetch stage directly downstream of the program counter register. Each cycle it reads the current PC and issues a request to instruction memory using a req/ack handshake. It captures the returned word into the IF/ID pipeline register and computes the next address (PC+4 or a branch redirect) that feeds back into the PC. It also drives the PC's hold input, so the PC advances only when a fetch completes or a redirect must be taken.

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/instruction_fetch_if.sv | 18 +
 rtl/instruction_fetch_holding.sv | 38 +++
 rtl/instruction_fetch.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// mips_fetch_pkg: shared definitions for the instruction fetch stage.
//   WORD_W        : datapath width (instruction words and addresses)
//   word_t        : one instruction word or byte address
//   NOP, RESET_PC : IF/ID contents after reset or flush
//   ST_*          : fetch FSM state encodings
package mips_fetch_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // sll $0,$0,0
  localparam word_t NOP      = 32'h0000_0000;
  localparam word_t RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: request/acknowledge read bus between the fetch stage
// and instruction memory.
//   req   : read request, held until ack
//   addr  : word-aligned read address, stable while req is high
//   ack   : one-cycle completion pulse
//   rdata : instruction word, valid in the ack cycle
interface instruction_fetch_if;
  import mips_fetch_pkg::*;

  logic  req;
  word_t addr;
  logic  ack;
  word_t rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/instruction_fetch_holding.sv
// fetch_holding_register: one-entry skid buffer for a fetched word that
// arrived while IF/ID was blocked.
//   clock, reset   : clock, async active-high reset
//   load           : capture in_word/in_pc
//   drain          : entry consumed by IF/ID
//   clear          : entry discarded (flush)
//   in_word, in_pc : word and its address
//   valid, word, pc: buffered entry
module fetch_holding_register
  import mips_fetch_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  load,
  input  logic  drain,
  input  logic  clear,
  input  word_t in_word,
  input  word_t in_pc,
  output logic  valid,
  output word_t word,
  output word_t pc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      word  <= NOP;
      pc    <= RESET_PC;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= in_word;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the PC register and IF/ID.
//   clock, reset       : clock, async active-high reset
//   pc                 : current PC
//   next_address       : value the PC loads when pc_hold is low
//   pc_hold            : 1 = PC keeps its value this cycle
//   imem               : instruction memory req/ack bus (master side)
//   stall              : decode cannot accept a new IF/ID entry
//   flush              : discard IF/ID, buffered word and in-flight fetch
//   branch_taken/target: redirect request (always with flush)
//   if_valid, if_instr, if_pc, if_pc_plus4 : IF/ID pipeline register
//
// state | meaning
// IDLE  | out of reset, no request yet
// FETCH | request outstanding for pc
// HOLD  | word buffered, IF/ID blocked by stall
// DRAIN | flushed fetch still in flight, its data will be dropped
module instruction_fetch
  import mips_fetch_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  word_t pc,
  output word_t next_address,
  output logic  pc_hold,
  instruction_fetch_if.master imem,
  input  logic  stall,
  input  logic  flush,
  input  logic  branch_taken,
  input  word_t branch_target,
  output logic  if_valid,
  output word_t if_instr,
  output word_t if_pc,
  output word_t if_pc_plus4
);

  fetch_state_t state, state_nxt;

  logic  slot_free;
  logic  fetch_ack, drain_ack;
  logic  take_fetch, take_buf, to_buf;
  logic  redir_valid;
  word_t redir_target;
  logic  buf_valid;
  word_t buf_word, buf_pc;

  assign slot_free = !if_valid || !stall;
  assign fetch_ack = (state == ST_FETCH) && imem.ack;
  assign drain_ack = (state == ST_DRAIN) && imem.ack;

  // Flush beats both a captured ack and a pending buffer transfer.
  assign take_fetch = fetch_ack && !flush && slot_free;
  assign to_buf     = fetch_ack && !flush && !slot_free;
  assign take_buf   = (state == ST_HOLD) && buf_valid && !flush && slot_free;

  assign imem.req  = (state == ST_FETCH) || (state == ST_DRAIN);
  assign imem.addr = {pc[31:2], 2'b00};

  // The PC moves once per completed fetch; IDLE/HOLD have nothing in flight,
  // so a flush there may redirect immediately.
  assign pc_hold = reset ||
                   !(fetch_ack || drain_ack ||
                     (flush && ((state == ST_IDLE) || (state == ST_HOLD))));

  assign next_address = branch_taken ? branch_target :
                        redir_valid  ? redir_target  :
                                       pc + 32'd4;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (flush) begin
          if (!imem.ack) state_nxt = ST_DRAIN;
        end else if (imem.ack && !slot_free) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD:  if (flush || slot_free) state_nxt = ST_FETCH;
      ST_DRAIN: if (imem.ack) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // A redirect seen while the PC is held is remembered until the PC moves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      redir_valid  <= 1'b0;
      redir_target <= RESET_PC;
    end else if (!pc_hold) begin
      redir_valid  <= 1'b0;
    end else if (branch_taken) begin
      redir_valid  <= 1'b1;
      redir_target <= branch_target;
    end
  end

  fetch_holding_register u_hold (
    .clock   (clock),
    .reset   (reset),
    .load    (to_buf),
    .drain   (take_buf),
    .clear   (flush),
    .in_word (imem.rdata),
    .in_pc   (pc),
    .valid   (buf_valid),
    .word    (buf_word),
    .pc      (buf_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_valid    <= 1'b0;
      if_instr    <= NOP;
      if_pc       <= RESET_PC;
      if_pc_plus4 <= RESET_PC + 32'd4;
    end else if (flush) begin
      if_valid    <= 1'b0;
      if_instr    <= NOP;
    end else if (take_fetch) begin
      if_valid    <= 1'b1;
      if_instr    <= imem.rdata;
      if_pc       <= pc;
      if_pc_plus4 <= pc + 32'd4;
    end else if (take_buf) begin
      if_valid    <= 1'b1;
      if_instr    <= buf_word;
      if_pc       <= buf_pc;
      if_pc_plus4 <= buf_pc + 32'd4;
    end else if (!stall) begin
      // entry consumed by decode and nothing new arrived
      if_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import mips_fetch_pkg::*;

  logic  clock = 1'b0;
  logic  reset;
  word_t pc;
  word_t next_address;
  logic  pc_hold;
  logic  stall, flush, branch_taken;
  word_t branch_target;
  logic  if_valid;
  word_t if_instr, if_pc, if_pc_plus4;

  instruction_fetch_if imem_bus ();

  instruction_fetch dut (
    .clock         (clock),
    .reset         (reset),
    .pc            (pc),
    .next_address  (next_address),
    .pc_hold       (pc_hold),
    .imem          (imem_bus),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus4   (if_pc_plus4)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic word_t mem_word(input word_t a);
    return 32'h2008_0005 + a;
  endfunction

  // ---------------- memory responder: ack after 'lat' request cycles -------
  int lat = 1;
  int cnt = 0;

  initial begin
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = 32'h0;
    forever begin
      @(negedge clock);
      imem_bus.ack = 1'b0;
      if (reset || !imem_bus.req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          imem_bus.ack   = 1'b1;
          imem_bus.rdata = mem_word(imem_bus.addr);
          cnt = 0;
        end
      end
    end
  end

  // ---------------- behavioural model + PC register + per-cycle compare ----
  typedef struct packed {
    word_t w;
    word_t a;
  } entry_t;

  entry_t buf_q[$];
  entry_t m_ifid, n_ifid;
  logic   m_ifv, n_ifv;
  logic   m_req, n_req, m_drop, n_drop, m_first;
  logic   m_pend, n_pend;
  word_t  m_pt, n_pt, m_pc, n_pc;
  logic   slot, adv;
  word_t  exp_next;

  task automatic model_reset();
    buf_q.delete();
    m_ifid  = '{NOP, RESET_PC};
    m_ifv   = 1'b0;
    m_req   = 1'b0;
    m_drop  = 1'b0;
    m_first = 1'b1;
    m_pend  = 1'b0;
    m_pt    = 32'h0;
    m_pc    = RESET_PC;
  endtask

  initial begin
    model_reset();
    pc = RESET_PC;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        model_reset();
        pc = m_pc;
        chk("rst_req",    imem_bus.req, 1'b0);
        chk("rst_hold",   pc_hold,      1'b1);
        chk("rst_valid",  if_valid,     1'b0);
        chk("rst_instr",  if_instr,     NOP);
        chk("rst_pc",     if_pc,        RESET_PC);
        chk("rst_plus4",  if_pc_plus4,  RESET_PC + 32'd4);
      end else begin
        slot     = !m_ifv || !stall;
        adv      = (m_req && imem_bus.ack) || (flush && !m_req);
        exp_next = branch_taken ? branch_target : (m_pend ? m_pt : m_pc + 32'd4);

        chk("req", imem_bus.req, m_req);
        if (m_req) chk("addr", imem_bus.addr, {m_pc[31:2], 2'b00});
        chk("pc_hold",  pc_hold,      !adv);
        chk("next_adr", next_address, exp_next);
        chk("valid",    if_valid,     m_ifv);
        chk("instr",    if_instr,     m_ifid.w);
        if (m_ifv) begin
          chk("if_pc",    if_pc,       m_ifid.a);
          chk("if_plus4", if_pc_plus4, m_ifid.a + 32'd4);
        end

        n_req  = m_req;
        n_drop = m_drop;
        n_ifv  = m_ifv;
        n_ifid = m_ifid;
        if (flush) begin
          n_ifv    = 1'b0;
          n_ifid.w = NOP;
          buf_q.delete();
          if (m_req) n_drop = !imem_bus.ack;
          else       n_req  = 1'b1;
        end else if (m_req && imem_bus.ack) begin
          if (m_drop) begin
            n_drop = 1'b0;
            if (!stall) n_ifv = 1'b0;
          end else if (slot) begin
            n_ifv  = 1'b1;
            n_ifid = '{imem_bus.rdata, m_pc};
          end else begin
            buf_q.push_back('{imem_bus.rdata, m_pc});
            n_req = 1'b0;
          end
        end else if (buf_q.size() > 0 && slot) begin
          n_ifv  = 1'b1;
          n_ifid = buf_q.pop_front();
          n_req  = 1'b1;
        end else begin
          if (m_first) n_req = 1'b1;
          if (!stall)  n_ifv = 1'b0;
        end

        n_pend = m_pend;
        n_pt   = m_pt;
        if (adv) n_pend = 1'b0;
        else if (branch_taken) begin
          n_pend = 1'b1;
          n_pt   = branch_target;
        end
        n_pc = adv ? exp_next : m_pc;

        @(posedge clock);
        #1;
        m_req   = n_req;
        m_drop  = n_drop;
        m_first = 1'b0;
        m_ifv   = n_ifv;
        m_ifid  = n_ifid;
        m_pend  = n_pend;
        m_pt    = n_pt;
        m_pc    = n_pc;
        pc      = m_pc;
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ------------
  // {stall, flush, branch_taken} per cycle, memory latency 2
  logic [2:0] vec [0:19] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b000,
                             3'b000, 3'b100, 3'b100, 3'b110, 3'b000,
                             3'b000, 3'b011, 3'b000, 3'b000, 3'b100,
                             3'b000, 3'b010, 3'b000, 3'b000, 3'b000};

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; lat = 1;
    repeat (2) @(negedge clock);
    #3 chk("lit_rst_plus4", if_pc_plus4, 32'h0000_0004);

    // zero-wait memory from reset
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #3;
    chk("lit_addr0", imem_bus.addr, 32'h0);
    chk("lit_hold0", pc_hold, 1'b0);
    @(negedge clock); #3;
    chk("lit_addr4", imem_bus.addr, 32'h4);
    chk("lit_valid_rise", if_valid, 1'b1);
    chk("lit_instr0", if_instr, 32'h2008_0005);
    @(negedge clock); #3;
    chk("lit_addr8", imem_bus.addr, 32'h8);
    chk("lit_ifpc4", if_pc, 32'h4);
    chk("lit_instr4", if_instr, 32'h2008_0009);

    // ack while stalled -> HOLD, IF/ID frozen, then release
    @(negedge clock); stall = 1'b1;
    #3 chk("lit_stall_ack_hold", pc_hold, 1'b0);
    @(negedge clock); #3;
    chk("lit_hold_req", imem_bus.req, 1'b0);
    chk("lit_hold_ifpc", if_pc, 32'h8);
    @(negedge clock);
    @(negedge clock); stall = 1'b0;
    #3 chk("lit_hold_release_pchold", pc_hold, 1'b1);
    @(negedge clock); #3;
    chk("lit_buf_ifpc", if_pc, 32'hC);
    chk("lit_buf_instr", if_instr, 32'h2008_0011);
    chk("lit_resume_addr", imem_bus.addr, 32'h10);

    // flush + ack in the same cycle, redirect to the top word
    @(negedge clock); flush = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    #3;
    chk("lit_flush_ack_next", next_address, 32'hFFFF_FFFC);
    chk("lit_flush_ack_hold", pc_hold, 1'b0);
    @(negedge clock); flush = 1'b0; branch_taken = 1'b0;
    #3;
    chk("lit_flush_valid", if_valid, 1'b0);
    chk("lit_top_addr", imem_bus.addr, 32'hFFFF_FFFC);
    chk("lit_wrap_next", next_address, 32'h0);
    @(negedge clock); #3;
    chk("lit_top_ifpc", if_pc, 32'hFFFF_FFFC);
    chk("lit_wrap_plus4", if_pc_plus4, 32'h0);
    chk("lit_wrap_addr", imem_bus.addr, 32'h0);
    repeat (3) @(negedge clock);

    // reset mid-fetch, then 3-cycle memory
    reset = 1'b1; lat = 3;
    #3;
    chk("lit_rst_req_drop", imem_bus.req, 1'b0);
    chk("lit_rst_pchold", pc_hold, 1'b1);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #3;
    chk("lit_lat_req", imem_bus.req, 1'b1);
    chk("lit_lat_hold1", pc_hold, 1'b1);
    @(negedge clock); #3;
    chk("lit_lat_hold2", pc_hold, 1'b1);
    @(negedge clock); #3;
    chk("lit_lat_ack_hold", pc_hold, 1'b0);
    chk("lit_lat_next", next_address, 32'h4);

    // flush with redirect mid-fetch -> DRAIN, late data dropped
    @(negedge clock); flush = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    #3;
    chk("lit_lat_instr", if_instr, 32'h2008_0005);
    chk("lit_lat_valid", if_valid, 1'b1);
    chk("lit_flush_nohold", pc_hold, 1'b1);
    @(negedge clock); flush = 1'b0; branch_taken = 1'b0;
    #3;
    chk("lit_drain_req", imem_bus.req, 1'b1);
    chk("lit_drain_valid", if_valid, 1'b0);
    chk("lit_drain_next", next_address, 32'h40);
    @(negedge clock); #3;
    chk("lit_drain_ack_hold", pc_hold, 1'b0);
    chk("lit_drain_ack_next", next_address, 32'h40);
    @(negedge clock); #3;
    chk("lit_redir_addr", imem_bus.addr, 32'h40);
    chk("lit_drop_valid", if_valid, 1'b0);
    repeat (3) @(negedge clock);
    #3;
    chk("lit_redir_ifpc", if_pc, 32'h40);
    chk("lit_redir_instr", if_instr, 32'h2008_0045);

    // mixed stall/flush sequence with 2-cycle memory
    @(negedge clock); reset = 1'b1; lat = 2;
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      stall         = vec[i][2];
      flush         = vec[i][1];
      branch_taken  = vec[i][0];
      branch_target = 32'h100;
    end
    @(negedge clock);
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    repeat (4) @(negedge clock);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
